// File: rtl/memory_stage_pkg.sv
// Shared types and constants for the MEM stage: access FSM encoding and the
// full-word byte-enable used for loads.
package memory_stage_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2
  } mem_state_e;

  localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/memory_stage_mem_req_ctrl.sv
// Data-memory access sequencer: tracks one outstanding request through the
// req/addr_ok/data_ok handshake and pulses done on the completing cycle.
module mem_req_ctrl
  import memory_stage_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic addr_ok,
  input  logic data_ok,
  output logic idle,
  output logic req,
  output logic done
);

  mem_state_e state_q, state_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= MEM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        // handshake strobes arriving here belong to no request and are dropped
        if (start) state_d = MEM_REQ;
      end
      MEM_REQ: begin
        if (addr_ok) begin
          if (data_ok) begin
            state_d = MEM_IDLE;
            done    = 1'b1;
          end else begin
            state_d = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        if (data_ok) begin
          state_d = MEM_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  assign idle = (state_q == MEM_IDLE);
  assign req  = (state_q == MEM_REQ);

endmodule

// File: rtl/memory_stage.sv
// MEM stage: issues loads/stores to the data-memory port and drives the
// registered WB/forwarding bus consumed by EXE.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              exe_valid,
  input  logic [DATA_W-1:0] exe_alu_result,
  input  logic              exe_wen,
  input  logic [REG_W-1:0]  exe_regsrc,
  input  logic              exe_is_load,
  input  logic              exe_is_store,
  input  logic [DATA_W-1:0] exe_store_data,
  input  logic [3:0]        exe_byte_en,
  output logic              mem_allowin,
  output logic              data_req,
  output logic              data_wr,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  output logic [3:0]        data_be,
  input  logic              data_addr_ok,
  input  logic [DATA_W-1:0] data_rdata,
  input  logic              data_data_ok,
  output logic              wb_wen,
  output logic [REG_W-1:0]  wb_regsrc,
  output logic [DATA_W-1:0] wb_data
);

  logic accept, mem_op, start, ctrl_idle, ctrl_req, ctrl_done;

  logic              data_wr_q, data_wr_d;
  logic [ADDR_W-1:0] data_addr_q, data_addr_d;
  logic [DATA_W-1:0] data_wdata_q, data_wdata_d;
  logic [3:0]        data_be_q, data_be_d;
  logic [REG_W-1:0]  acc_regsrc_q, acc_regsrc_d;
  logic              acc_wen_q, acc_wen_d;
  logic              wb_wen_q, wb_wen_d;
  logic [REG_W-1:0]  wb_regsrc_q, wb_regsrc_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  assign mem_allowin = ctrl_idle;
  assign accept      = exe_valid & mem_allowin;
  assign mem_op      = exe_is_load | exe_is_store;
  assign start       = accept & mem_op;

  mem_req_ctrl u_req_ctrl (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .addr_ok (data_addr_ok),
    .data_ok (data_data_ok),
    .idle    (ctrl_idle),
    .req     (ctrl_req),
    .done    (ctrl_done)
  );

  always_comb begin
    data_wr_d    = data_wr_q;
    data_addr_d  = data_addr_q;
    data_wdata_d = data_wdata_q;
    data_be_d    = data_be_q;
    acc_regsrc_d = acc_regsrc_q;
    acc_wen_d    = acc_wen_q;
    wb_wen_d     = 1'b0;
    wb_regsrc_d  = wb_regsrc_q;
    wb_data_d    = wb_data_q;

    // request fields are frozen from accept until the access completes
    if (start) begin
      data_wr_d    = exe_is_store;
      data_addr_d  = ADDR_W'(exe_alu_result);
      data_wdata_d = exe_store_data;
      data_be_d    = exe_is_store ? exe_byte_en : BE_WORD;
      acc_regsrc_d = exe_regsrc;
      acc_wen_d    = exe_wen;
    end

    if (accept && !mem_op) begin
      wb_wen_d    = exe_wen & (exe_regsrc != '0);
      wb_regsrc_d = exe_regsrc;
      wb_data_d   = exe_alu_result;
    end else if (ctrl_done) begin
      // r0 is hard-wired, so a zero destination never raises wb_wen
      wb_wen_d    = ~data_wr_q & acc_wen_q & (acc_regsrc_q != '0);
      wb_regsrc_d = acc_regsrc_q;
      wb_data_d   = data_wr_q ? wb_data_q : data_rdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_wr_q    <= 1'b0;
      data_addr_q  <= '0;
      data_wdata_q <= '0;
      data_be_q    <= '0;
      acc_regsrc_q <= '0;
      acc_wen_q    <= 1'b0;
      wb_wen_q     <= 1'b0;
      wb_regsrc_q  <= '0;
      wb_data_q    <= '0;
    end else begin
      data_wr_q    <= data_wr_d;
      data_addr_q  <= data_addr_d;
      data_wdata_q <= data_wdata_d;
      data_be_q    <= data_be_d;
      acc_regsrc_q <= acc_regsrc_d;
      acc_wen_q    <= acc_wen_d;
      wb_wen_q     <= wb_wen_d;
      wb_regsrc_q  <= wb_regsrc_d;
      wb_data_q    <= wb_data_d;
    end
  end

  assign data_req   = ctrl_req;
  assign data_wr    = data_wr_q;
  assign data_addr  = data_addr_q;
  assign data_wdata = data_wdata_q;
  assign data_be    = data_be_q;
  assign wb_wen     = wb_wen_q;
  assign wb_regsrc  = wb_regsrc_q;
  assign wb_data    = wb_data_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus randomized
// ALU/load/store traffic against an instruction-level reference model.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        exe_valid, exe_wen, exe_is_load, exe_is_store;
  logic [31:0] exe_alu_result, exe_store_data;
  logic [4:0]  exe_regsrc;
  logic [3:0]  exe_byte_en;
  logic        mem_allowin, data_req, data_wr;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_be;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        wb_wen;
  logic [4:0]  wb_regsrc;
  logic [31:0] wb_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk(clk), .resetn(resetn),
    .exe_valid(exe_valid), .exe_alu_result(exe_alu_result), .exe_wen(exe_wen),
    .exe_regsrc(exe_regsrc), .exe_is_load(exe_is_load), .exe_is_store(exe_is_store),
    .exe_store_data(exe_store_data), .exe_byte_en(exe_byte_en),
    .mem_allowin(mem_allowin), .data_req(data_req), .data_wr(data_wr),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_be(data_be),
    .data_addr_ok(data_addr_ok), .data_rdata(data_rdata), .data_data_ok(data_data_ok),
    .wb_wen(wb_wen), .wb_regsrc(wb_regsrc), .wb_data(wb_data)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    exe_valid = 0; exe_wen = 0; exe_is_load = 0; exe_is_store = 0;
    exe_alu_result = 0; exe_store_data = 0; exe_regsrc = 0; exe_byte_en = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
  endtask

  // ALU instruction: result appears on the WB bus the cycle after accept
  task automatic do_alu(input logic wen, input logic [4:0] rs, input logic [31:0] val);
    logic exp_wen;
    exp_wen = wen && (rs != 0);
    tests++;
    if (mem_allowin !== 1'b1) begin
      fails++; $display("FAIL alu_allowin: got %b want 1", mem_allowin);
    end
    exe_valid = 1; exe_is_load = 0; exe_is_store = 0;
    exe_wen = wen; exe_regsrc = rs; exe_alu_result = val;
    step();
    exe_valid = 0;
    tests++;
    if (wb_wen !== exp_wen) begin
      fails++; $display("FAIL alu_wb_wen: got %b want %b (rs=%0d)", wb_wen, exp_wen, rs);
    end
    if (exp_wen) begin
      tests++;
      if (wb_regsrc !== rs || wb_data !== val) begin
        fails++; $display("FAIL alu_wb_bus: got rs=%0d data=%h want rs=%0d data=%h",
                          wb_regsrc, wb_data, rs, val);
      end
    end
    $display("[TB] alu   wen=%b rs=%0d val=%h -> wb_wen=%b", wen, rs, val, wb_wen);
  endtask

  // Load/store: memory accepts addr after addr_lat extra req cycles and returns
  // data_lat cycles after that (0/0 = both strobes on the first req cycle)
  task automatic do_mem(input logic is_store, input logic wen, input logic [4:0] rs,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] rdata,
                        input int addr_lat, input int data_lat);
    logic [3:0] exp_be;
    logic       exp_wen;
    int         req_cycles;
    exp_be     = is_store ? be : 4'hF;
    exp_wen    = !is_store && wen && (rs != 0);
    req_cycles = 0;
    tests++;
    if (mem_allowin !== 1'b1) begin
      fails++; $display("FAIL mem_allowin_start: got %b want 1", mem_allowin);
    end
    exe_valid = 1; exe_is_load = !is_store; exe_is_store = is_store;
    exe_wen = wen; exe_regsrc = rs; exe_alu_result = addr;
    exe_store_data = wdata; exe_byte_en = be;
    step();
    // keep offering a conflicting ALU op; it must not be taken while busy
    exe_is_load = 0; exe_is_store = 0; exe_wen = 1; exe_regsrc = 5'd9;
    exe_alu_result = $urandom; exe_store_data = $urandom; exe_byte_en = 4'($urandom);
    for (int c = 0; c <= addr_lat; c++) begin
      req_cycles++;
      tests++;
      if (data_req !== 1'b1 || data_wr !== is_store || data_addr !== addr ||
          data_be !== exp_be || (is_store && data_wdata !== wdata) ||
          mem_allowin !== 1'b0 || wb_wen !== 1'b0) begin
        fails++;
        $display("FAIL req_phase c=%0d: got req=%b wr=%b addr=%h be=%h wdata=%h allowin=%b wb_wen=%b want req=1 wr=%b addr=%h be=%h wdata=%h allowin=0 wb_wen=0",
                 c, data_req, data_wr, data_addr, data_be, data_wdata, mem_allowin, wb_wen,
                 is_store, addr, exp_be, wdata);
      end
      data_rdata = $urandom;
      if (c == addr_lat) begin
        data_addr_ok = 1;
        if (data_lat == 0) begin data_data_ok = 1; data_rdata = rdata; end
      end
      step();
      data_addr_ok = 0; data_data_ok = 0;
    end
    for (int d = 1; d <= data_lat; d++) begin
      tests++;
      if (data_req !== 1'b0 || mem_allowin !== 1'b0 || wb_wen !== 1'b0) begin
        fails++;
        $display("FAIL wait_phase d=%0d: got req=%b allowin=%b wb_wen=%b want 0 0 0",
                 d, data_req, mem_allowin, wb_wen);
      end
      data_rdata = $urandom;
      if (d == data_lat) begin data_data_ok = 1; data_rdata = rdata; end
      step();
      data_data_ok = 0;
    end
    exe_valid = 0;
    tests++;
    if (wb_wen !== exp_wen || mem_allowin !== 1'b1 || data_req !== 1'b0) begin
      fails++;
      $display("FAIL mem_complete: got wb_wen=%b allowin=%b req=%b want wb_wen=%b allowin=1 req=0",
               wb_wen, mem_allowin, data_req, exp_wen);
    end
    if (exp_wen) begin
      tests++;
      if (wb_regsrc !== rs || wb_data !== rdata) begin
        fails++; $display("FAIL load_wb_bus: got rs=%0d data=%h want rs=%0d data=%h",
                          wb_regsrc, wb_data, rs, rdata);
      end
    end
    step();
    tests++;
    if (wb_wen !== 1'b0) begin
      fails++; $display("FAIL wb_single_pulse: got wb_wen=%b want 0", wb_wen);
    end
    $display("[TB] %s rs=%0d addr=%h lat=%0d/%0d req_cycles=%0d",
             is_store ? "store" : "load ", rs, addr, addr_lat, data_lat, req_cycles);
  endtask

  task automatic test_reset();
    clear_inputs();
    resetn = 0;
    step(); step();
    tests++;
    if (data_req !== 0 || data_wr !== 0 || data_addr !== 0 || data_wdata !== 0 ||
        data_be !== 0 || wb_wen !== 0 || wb_regsrc !== 0 || wb_data !== 0 || mem_allowin !== 1) begin
      fails++;
      $display("FAIL reset_state: got req=%b wr=%b addr=%h wdata=%h be=%h wb_wen=%b rs=%0d wb_data=%h allowin=%b want all 0 allowin=1",
               data_req, data_wr, data_addr, data_wdata, data_be, wb_wen, wb_regsrc, wb_data, mem_allowin);
    end
    resetn = 1;
    step();
    $display("[TB] reset released");
  endtask

  task automatic test_alu();
    do_alu(1'b1, 5'd8, 32'h1234);
    for (int i = 0; i < 4; i++) do_alu(1'($urandom), 5'($urandom_range(1, 31)), $urandom);
  endtask

  task automatic test_load_zero_wait();
    do_mem(1'b0, 1'b1, 5'd3, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 0, 0);
  endtask

  task automatic test_load_delayed();
    do_mem(1'b0, 1'b1, 5'd12, 32'h2000, 32'h0, 4'h0, 32'hCAFEF00D, 3, 2);
  endtask

  task automatic test_store();
    do_mem(1'b1, 1'b1, 5'd4, 32'h200, 32'hAABBCCDD, 4'b0011, 32'h11111111, 1, 1);
  endtask

  task automatic test_r0();
    do_alu(1'b1, 5'd0, 32'h5555);
    do_mem(1'b0, 1'b1, 5'd0, 32'h300, 32'h0, 4'h0, 32'h77777777, 0, 1);
  endtask

  task automatic test_stray_ack();
    data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'hBAD0BAD0;
    step(); step();
    data_addr_ok = 0; data_data_ok = 0;
    tests++;
    if (data_req !== 0 || wb_wen !== 0 || mem_allowin !== 1) begin
      fails++; $display("FAIL stray_ack: got req=%b wb_wen=%b allowin=%b want 0 0 1",
                        data_req, wb_wen, mem_allowin);
    end
    $display("[TB] stray ack in idle");
  endtask

  task automatic test_reset_mid_wait();
    exe_valid = 1; exe_is_load = 1; exe_is_store = 0; exe_wen = 1;
    exe_regsrc = 5'd6; exe_alu_result = 32'h400;
    step();
    exe_valid = 0; exe_is_load = 0;
    data_addr_ok = 1;
    step();
    data_addr_ok = 0;
    tests++;
    if (data_req !== 0 || mem_allowin !== 0) begin
      fails++; $display("FAIL wait_entry: got req=%b allowin=%b want 0 0", data_req, mem_allowin);
    end
    #2 resetn = 0;
    #1;
    tests++;
    if (data_req !== 0 || mem_allowin !== 1 || wb_wen !== 0) begin
      fails++; $display("FAIL async_reset: got req=%b allowin=%b wb_wen=%b want 0 1 0",
                        data_req, mem_allowin, wb_wen);
    end
    #3 resetn = 1;
    step();
    data_data_ok = 1; data_rdata = 32'h0BADF00D;
    step();
    data_data_ok = 0;
    tests++;
    if (wb_wen !== 0 || mem_allowin !== 1 || data_req !== 0) begin
      fails++; $display("FAIL late_data_ok: got wb_wen=%b allowin=%b req=%b want 0 1 0",
                        wb_wen, mem_allowin, data_req);
    end
    $display("[TB] reset during wait, late data_ok dropped");
  endtask

  task automatic test_back_to_back();
    logic [4:0]  rs_q[$];
    logic [31:0] val_q[$];
    logic        wen_q[$];
    for (int i = 0; i < 6; i++) begin
      rs_q.push_back(5'($urandom_range(0, 31)));
      val_q.push_back($urandom);
      wen_q.push_back(1'($urandom));
    end
    exe_is_load = 0; exe_is_store = 0;
    while (rs_q.size() > 0) begin
      logic [4:0]  rs;
      logic [31:0] val;
      logic        wen, exp_wen;
      rs = rs_q.pop_front(); val = val_q.pop_front(); wen = wen_q.pop_front();
      exe_valid = 1; exe_wen = wen; exe_regsrc = rs; exe_alu_result = val;
      step();
      exp_wen = wen && (rs != 0);
      tests++;
      if (wb_wen !== exp_wen || (exp_wen && (wb_regsrc !== rs || wb_data !== val))) begin
        fails++; $display("FAIL back_to_back: got wen=%b rs=%0d data=%h want wen=%b rs=%0d data=%h",
                          wb_wen, wb_regsrc, wb_data, exp_wen, rs, val);
      end
      $display("[TB] b2b   rs=%0d val=%h wb_wen=%b", rs, val, wb_wen);
    end
    exe_valid = 0;
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      if (kind == 0)
        do_alu(1'($urandom), 5'($urandom_range(0, 31)), $urandom);
      else
        do_mem(kind == 2, 1'($urandom), 5'($urandom_range(0, 31)), $urandom, $urandom,
               4'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  initial begin
    clear_inputs();
    resetn = 0;
    test_reset();
    test_alu();
    test_load_zero_wait();
    test_load_delayed();
    test_store();
    test_r0();
    test_stray_ack();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
